sd_xfer_sequencer: RTL and testbench
====================================

// Module: sd_xfer_sequencer
// PURPOSE
//  Sequences one complete SD transaction across the existing CMD, ADMA and DAT blocks in CLK domain.
//  Launches the command and waits for its response. For data commands it then starts the DMA and
//  waits for both DMA and DAT completion. Issues auto-CMD12 after multi-block transfers.
//  Drives the inhibit flags, completion pulses and error status that sd_host maps into PSR/NISR/EISR.
// PARAMETERS
//  TO_W        16     width of watchdog counter
//  TO_CYCLES   50000  CLK cycles allowed per wait state before timeout (must be < 2**TO_W)
//  STOP_IDX    6'd12  command index issued for auto-stop
// PORTS
//  CLK          in   1   host clock, all logic rising-edge
//  RESET        in   1   asynchronous, active-high reset
//  start_flag   in   1   1-cycle pulse: software wrote command register
//  cmd_index    in   6   command index (CR[13:8]); sampled on accepted start_flag
//  data_present in   1   command has data phase (CR[5]); sampled on accepted start_flag
//  block_count  in   16  blocks to transfer (BCR); sampled on accepted start_flag
//  cmd_complete in   1   pulse from CMD: response received
//  cmd_timeout  in   1   pulse from CMD: response timeout
//  dma_done     in   1   pulse from ADMA: descriptor chain finished
//  dma_error    in   1   pulse from ADMA: descriptor/transfer error
//  dat_done     in   1   pulse from DAT: last block finished on DAT lines
//  STOP         in   1   core request to abort data transfer (level)
//  new_cmd      out  1   1-cycle pulse to CMD: send command
//  cmd_idx_out  out  6   index presented to CMD, valid while new_cmd high
//  dma_start    out  1   1-cycle pulse to ADMA: start transfer
//  cmd_inhibit  out  1   PSR[0]: sequencer busy
//  dat_inhibit  out  1   PSR[1]: data phase pending/active
//  cmd_done     out  1   1-cycle pulse: NISR[0] command complete
//  tf_complete  out  1   1-cycle pulse: NISR[1] transfer complete
//  err_status   out  4   sticky: [0] cmd timeout [1] data timeout [2] dma error [3] aborted
//  seq_state    out  3   current state encoding (debug)
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; watchdog 0; latched fields 0; done-flags cleared. Applies mid-transaction, no pulses after release.
//  - States (seq_state): IDLE=0 SEND_CMD=1 WAIT_RESP=2 START_DATA=3 WAIT_DATA=4 SEND_STOP=5 WAIT_STOP=6 FINISH=7.
//  - IDLE: start_flag -> latch cmd_index/data_present/block_count, clear err_status -> SEND_CMD. Ignored in all other states.
//  - SEND_CMD: new_cmd=1 and cmd_idx_out=latched index for exactly this cycle -> WAIT_RESP.
//    new_cmd rises the cycle after start_flag.
//  - WAIT_RESP: cmd_timeout or watchdog expiry -> err[0], FINISH. cmd_complete -> cmd_done pulse next cycle;
//    then START_DATA if data_present && block_count!=0, else FINISH. Timeout and complete together: timeout wins.
//  - START_DATA: dma_start=1 for one cycle -> WAIT_DATA; clear dma_seen/dat_seen flags.
//  - WAIT_DATA: dma_done/dat_done set their flags; exits when both seen (any order, same cycle allowed).
//  - WAIT_DATA exit targets: both flags set -> SEND_STOP if block_count>1, else FINISH.
//  - WAIT_DATA errors: dma_error -> err[2]; STOP=1 -> err[3]; watchdog expiry -> err[1].
//    Any of these -> SEND_STOP if block_count>1, else FINISH.
//  - WAIT_DATA priority same cycle: completion > dma_error > STOP > watchdog. STOP is ignored outside START_DATA/WAIT_DATA.
//  - SEND_STOP: new_cmd=1, cmd_idx_out=STOP_IDX, one cycle -> WAIT_STOP.
//  - WAIT_STOP: cmd_complete -> FINISH (no cmd_done). cmd_timeout or watchdog -> err[0], FINISH.
//  - FINISH: tf_complete=1 for one cycle if data phase was entered and err[2:1]==0 and err[3]==0 -> IDLE.
//  - Watchdog: loads 0 on entry to WAIT_RESP/WAIT_DATA/WAIT_STOP and increments each cycle in them.
//    Expiry when count==TO_CYCLES-1 with no exit event that cycle. Saturates, never wraps.
//  - cmd_inhibit = (state!=IDLE). dat_inhibit = latched data_present && state in SEND_CMD..FINISH.
//  - err_status holds until next accepted start_flag. All pulse outputs are registered.
// TESTING
//  - No-data cmd: start_flag idx=8, data_present=0; cmd_complete 5 cycles later.
//    Expect new_cmd 1 cycle after start, idx 8, cmd_done once, tf_complete never, IDLE within 2 cycles.
//  - Single block: data_present=1, count=1; dat_done 3 cycles before dma_done.
//    Expect dma_start once, tf_complete once, no CMD12, err_status=0.
//  - Multi block: count=4; dma_done and dat_done same cycle.
//    Expect new_cmd with idx 12 after data, tf_complete after its cmd_complete.
//  - Timeouts: TO_CYCLES=16, no cmd_complete -> err=4'b0001 at cycle 16 in WAIT_RESP.
//    Data phase with no dat_done -> err=4'b0010, CMD12 issued when count>1.
//  - STOP=1 mid WAIT_DATA, count=2 -> err[3]=1, CMD12 sent, no tf_complete. start_flag while busy is ignored.
//  - Async RESET asserted in WAIT_DATA -> all outputs 0 immediately; a fresh start_flag after release sequences normally.

Source files
------------

// File: rtl/sd_xfer_sequencer.sv
// rtl/sd_xfer_sequencer.sv - sequences one SD transaction across CMD, ADMA and DAT blocks
// Command, optional DMA data phase, optional auto-stop, then completion/error reporting.
module sd_xfer_sequencer #(
  parameter int          TO_W      = 16,
  parameter int          TO_CYCLES = 50000,
  parameter logic [5:0]  STOP_IDX  = 6'd12
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start_flag,
  input  logic [5:0]  cmd_index,
  input  logic        data_present,
  input  logic [15:0] block_count,
  input  logic        cmd_complete,
  input  logic        cmd_timeout,
  input  logic        dma_done,
  input  logic        dma_error,
  input  logic        dat_done,
  input  logic        STOP,
  output logic        new_cmd,
  output logic [5:0]  cmd_idx_out,
  output logic        dma_start,
  output logic        cmd_inhibit,
  output logic        dat_inhibit,
  output logic        cmd_done,
  output logic        tf_complete,
  output logic [3:0]  err_status,
  output logic [2:0]  seq_state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SEND_CMD   = 3'd1,
    WAIT_RESP  = 3'd2,
    START_DATA = 3'd3,
    WAIT_DATA  = 3'd4,
    SEND_STOP  = 3'd5,
    WAIT_STOP  = 3'd6,
    FINISH     = 3'd7
  } state_t;

  localparam logic [TO_W-1:0] WD_LAST = TO_W'(TO_CYCLES - 1);

  state_t          state;
  logic [5:0]      lat_idx;
  logic            lat_data;
  logic [15:0]     lat_count;
  logic [TO_W-1:0] wd;
  logic            dma_seen;
  logic            dat_seen;
  logic            data_entered;

  logic wd_expired;
  logic in_wait;
  logic multi_block;
  logic dma_seen_nx;
  logic dat_seen_nx;
  logic data_both;
  logic data_exit;

  assign wd_expired  = (wd == WD_LAST);
  assign in_wait     = (state == WAIT_RESP) || (state == WAIT_DATA) || (state == WAIT_STOP);
  assign multi_block = (lat_count > 16'd1);
  assign dma_seen_nx = dma_seen | dma_done;
  assign dat_seen_nx = dat_seen | dat_done;
  assign data_both   = dma_seen_nx & dat_seen_nx;
  assign data_exit   = data_both | dma_error | STOP | wd_expired;

  assign cmd_inhibit = (state != IDLE);
  assign dat_inhibit = lat_data && (state != IDLE);
  assign seq_state   = state;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state        <= IDLE;
      lat_idx      <= 6'd0;
      lat_data     <= 1'b0;
      lat_count    <= 16'd0;
      wd           <= '0;
      dma_seen     <= 1'b0;
      dat_seen     <= 1'b0;
      data_entered <= 1'b0;
      new_cmd      <= 1'b0;
      cmd_idx_out  <= 6'd0;
      dma_start    <= 1'b0;
      cmd_done     <= 1'b0;
      tf_complete  <= 1'b0;
      err_status   <= 4'd0;
    end else begin
      new_cmd     <= 1'b0;
      cmd_idx_out <= 6'd0;
      dma_start   <= 1'b0;
      cmd_done    <= 1'b0;
      tf_complete <= 1'b0;
      // Watchdog saturates at its last value so it can never wrap back to a live count.
      if (in_wait && !wd_expired)
        wd <= wd + 1'b1;

      case (state)
        IDLE: begin
          if (start_flag) begin
            lat_idx      <= cmd_index;
            lat_data     <= data_present;
            lat_count    <= block_count;
            err_status   <= 4'd0;
            data_entered <= 1'b0;
            new_cmd      <= 1'b1;
            cmd_idx_out  <= cmd_index;
            state        <= SEND_CMD;
          end
        end

        SEND_CMD: begin
          wd    <= '0;
          state <= WAIT_RESP;
        end

        WAIT_RESP: begin
          if (cmd_timeout) begin
            err_status[0] <= 1'b1;
            state         <= FINISH;
          end else if (cmd_complete) begin
            cmd_done <= 1'b1;
            if (lat_data && (lat_count != 16'd0)) begin
              dma_start    <= 1'b1;
              data_entered <= 1'b1;
              state        <= START_DATA;
            end else begin
              state <= FINISH;
            end
          end else if (wd_expired) begin
            err_status[0] <= 1'b1;
            state         <= FINISH;
          end
        end

        START_DATA: begin
          dma_seen <= 1'b0;
          dat_seen <= 1'b0;
          wd       <= '0;
          state    <= WAIT_DATA;
        end

        WAIT_DATA: begin
          dma_seen <= dma_seen_nx;
          dat_seen <= dat_seen_nx;
          if (!data_both) begin
            if (dma_error)
              err_status[2] <= 1'b1;
            else if (STOP)
              err_status[3] <= 1'b1;
            else if (wd_expired)
              err_status[1] <= 1'b1;
          end
          if (data_exit) begin
            if (multi_block) begin
              new_cmd     <= 1'b1;
              cmd_idx_out <= STOP_IDX;
              state       <= SEND_STOP;
            end else begin
              // Clean single-block completion; any data error above blocks the pulse.
              tf_complete <= data_both && (err_status[3:1] == 3'd0);
              state       <= FINISH;
            end
          end
        end

        SEND_STOP: begin
          wd    <= '0;
          state <= WAIT_STOP;
        end

        WAIT_STOP: begin
          if (cmd_timeout || (!cmd_complete && wd_expired)) begin
            err_status[0] <= 1'b1;
            tf_complete   <= data_entered && (err_status[3:1] == 3'd0);
            state         <= FINISH;
          end else if (cmd_complete) begin
            tf_complete <= data_entered && (err_status[3:1] == 3'd0);
            state       <= FINISH;
          end
        end

        FINISH: begin
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_xfer_sequencer.sv
// tb/tb_sd_xfer_sequencer.sv - table-driven bench for sd_xfer_sequencer
// Each row: inputs for one cycle and the outputs expected just after the following rising edge.
module tb_sd_xfer_sequencer;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        start_flag = 1'b0;
  logic [5:0]  cmd_index = 6'd0;
  logic        data_present = 1'b0;
  logic [15:0] block_count = 16'd0;
  logic        cmd_complete = 1'b0;
  logic        cmd_timeout = 1'b0;
  logic        dma_done = 1'b0;
  logic        dma_error = 1'b0;
  logic        dat_done = 1'b0;
  logic        STOP = 1'b0;
  logic        new_cmd;
  logic [5:0]  cmd_idx_out;
  logic        dma_start;
  logic        cmd_inhibit;
  logic        dat_inhibit;
  logic        cmd_done;
  logic        tf_complete;
  logic [3:0]  err_status;
  logic [2:0]  seq_state;

  sd_xfer_sequencer #(.TO_W(16), .TO_CYCLES(16), .STOP_IDX(6'd12)) dut (
    .CLK(CLK), .RESET(RESET), .start_flag(start_flag), .cmd_index(cmd_index),
    .data_present(data_present), .block_count(block_count), .cmd_complete(cmd_complete),
    .cmd_timeout(cmd_timeout), .dma_done(dma_done), .dma_error(dma_error), .dat_done(dat_done),
    .STOP(STOP), .new_cmd(new_cmd), .cmd_idx_out(cmd_idx_out), .dma_start(dma_start),
    .cmd_inhibit(cmd_inhibit), .dat_inhibit(dat_inhibit), .cmd_done(cmd_done),
    .tf_complete(tf_complete), .err_status(err_status), .seq_state(seq_state)
  );

  always #5 CLK = ~CLK;

  localparam logic [6:0] S  = 7'b1000000;
  localparam logic [6:0] CC = 7'b0100000;
  localparam logic [6:0] CT = 7'b0010000;
  localparam logic [6:0] DT = 7'b0001000;
  localparam logic [6:0] DM = 7'b0000100;
  localparam logic [6:0] DE = 7'b0000010;
  localparam logic [6:0] SP = 7'b0000001;

  typedef struct {
    logic [6:0]  fl;
    logic [5:0]  idx;
    logic [15:0] cnt;
    logic        dp;
    logic [2:0]  st;
    logic        nc;
    logic [5:0]  oidx;
    logic        ds;
    logic        di;
    logic        cd;
    logic        tf;
    logic [3:0]  err;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;
  int   split;

  task automatic add(input logic [6:0] fl, input logic [5:0] idx, input logic [15:0] cnt,
                     input logic dp, input logic [2:0] st, input logic nc, input logic [5:0] oidx,
                     input logic ds, input logic di, input logic cd, input logic tf,
                     input logic [3:0] err);
    vec_t v;
    v.fl = fl; v.idx = idx; v.cnt = cnt; v.dp = dp; v.st = st; v.nc = nc; v.oidx = oidx;
    v.ds = ds; v.di = di; v.cd = cd; v.tf = tf; v.err = err;
    tbl.push_back(v);
  endtask

  task automatic hold(input int n, input logic [2:0] st, input logic di, input logic [3:0] err);
    for (int i = 0; i < n; i++)
      add(7'd0, 6'd0, 16'd0, 1'b0, st, 1'b0, 6'd0, 1'b0, di, 1'b0, 1'b0, err);
  endtask

  function automatic logic [18:0] dut_out();
    return {seq_state, new_cmd, cmd_idx_out, dma_start, cmd_inhibit, dat_inhibit,
            cmd_done, tf_complete, err_status};
  endfunction

  task automatic chk(input string name, input logic [18:0] act, input logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got st=%0d nc=%b idx=%0d ds=%b ci=%b di=%b cd=%b tf=%b err=%b, expected st=%0d nc=%b idx=%0d ds=%b ci=%b di=%b cd=%b tf=%b err=%b",
               name, act[18:16], act[15], act[14:9], act[8], act[7], act[6], act[5], act[4], act[3:0],
               exp[18:16], exp[15], exp[14:9], exp[8], exp[7], exp[6], exp[5], exp[4], exp[3:0]);
    end
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      vec_t v;
      v = tbl[i];
      @(negedge CLK);
      start_flag   = v.fl[6];
      cmd_complete = v.fl[5];
      cmd_timeout  = v.fl[4];
      dat_done     = v.fl[3];
      dma_done     = v.fl[2];
      dma_error    = v.fl[1];
      STOP         = v.fl[0];
      cmd_index    = v.idx;
      block_count  = v.cnt;
      data_present = v.dp;
      @(posedge CLK);
      #1;
      chk($sformatf("row%0d", i), dut_out(),
          {v.st, v.nc, v.oidx, v.ds, (v.st != 3'd0), v.di, v.cd, v.tf, v.err});
    end
    @(negedge CLK);
    {start_flag, cmd_complete, cmd_timeout, dat_done, dma_done, dma_error, STOP} = 7'd0;
  endtask

  initial begin
    // No-data command, response 5 cycles after start
    add(S, 6'd8, 16'd0, 1'b0, 3'd1, 1'b1, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    hold(4, 3'd2, 1'b0, 4'd0);
    add(CC, 6'd0, 16'd0, 1'b0, 3'd7, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    hold(2, 3'd0, 1'b0, 4'd0);
    // Response watchdog expiry on the 16th WAIT_RESP cycle
    add(S, 6'd5, 16'd0, 1'b0, 3'd1, 1'b1, 6'd5, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    hold(16, 3'd2, 1'b0, 4'd0);
    add(7'd0, 6'd0, 16'd0, 1'b0, 3'd7, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001);
    hold(1, 3'd0, 1'b0, 4'b0001);
    // Single block, dat_done 3 cycles before dma_done
    add(S, 6'd17, 16'd1, 1'b1, 3'd1, 1'b1, 6'd17, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    hold(1, 3'd2, 1'b1, 4'd0);
    add(CC, 6'd0, 16'd0, 1'b0, 3'd3, 1'b0, 6'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    hold(1, 3'd4, 1'b1, 4'd0);
    add(DT, 6'd0, 16'd0, 1'b0, 3'd4, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    hold(2, 3'd4, 1'b1, 4'd0);
    add(DM, 6'd0, 16'd0, 1'b0, 3'd7, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    hold(2, 3'd0, 1'b0, 4'd0);
    // Multi block, both completions together, then auto CMD12
    add(S, 6'd18, 16'd4, 1'b1, 3'd1, 1'b1, 6'd18, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    hold(1, 3'd2, 1'b1, 4'd0);
    add(CC, 6'd0, 16'd0, 1'b0, 3'd3, 1'b0, 6'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    hold(1, 3'd4, 1'b1, 4'd0);
    add(DT | DM, 6'd0, 16'd0, 1'b0, 3'd5, 1'b1, 6'd12, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    hold(1, 3'd6, 1'b1, 4'd0);
    add(CC, 6'd0, 16'd0, 1'b0, 3'd7, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    hold(1, 3'd0, 1'b0, 4'd0);
    // Timeout and complete together: timeout wins, no data phase
    add(S, 6'd9, 16'd2, 1'b1, 3'd1, 1'b1, 6'd9, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    hold(1, 3'd2, 1'b1, 4'd0);
    add(CC | CT, 6'd0, 16'd0, 1'b0, 3'd7, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0001);
    hold(1, 3'd0, 1'b0, 4'b0001);
    // Data watchdog, count 3: dma_done only, then CMD12
    add(S, 6'd25, 16'd3, 1'b1, 3'd1, 1'b1, 6'd25, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    hold(1, 3'd2, 1'b1, 4'd0);
    add(CC, 6'd0, 16'd0, 1'b0, 3'd3, 1'b0, 6'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    hold(1, 3'd4, 1'b1, 4'd0);
    add(DM, 6'd0, 16'd0, 1'b0, 3'd4, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    hold(14, 3'd4, 1'b1, 4'd0);
    add(7'd0, 6'd0, 16'd0, 1'b0, 3'd5, 1'b1, 6'd12, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010);
    hold(1, 3'd6, 1'b1, 4'b0010);
    add(CC, 6'd0, 16'd0, 1'b0, 3'd7, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0010);
    hold(1, 3'd0, 1'b0, 4'b0010);
    // STOP mid data, count 2; start_flag while busy ignored
    add(S, 6'd18, 16'd2, 1'b1, 3'd1, 1'b1, 6'd18, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    add(S, 6'd40, 16'd1, 1'b0, 3'd2, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    add(CC, 6'd0, 16'd0, 1'b0, 3'd3, 1'b0, 6'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    hold(1, 3'd4, 1'b1, 4'd0);
    add(S, 6'd40, 16'd1, 1'b0, 3'd4, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    add(SP, 6'd0, 16'd0, 1'b0, 3'd5, 1'b1, 6'd12, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000);
    add(SP, 6'd0, 16'd0, 1'b0, 3'd6, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000);
    add(CC, 6'd0, 16'd0, 1'b0, 3'd7, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1000);
    hold(1, 3'd0, 1'b0, 4'b1000);
    // dma_error beats STOP in the same cycle, count 1
    add(S, 6'd20, 16'd1, 1'b1, 3'd1, 1'b1, 6'd20, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    hold(1, 3'd2, 1'b1, 4'd0);
    add(CC, 6'd0, 16'd0, 1'b0, 3'd3, 1'b0, 6'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    hold(1, 3'd4, 1'b1, 4'd0);
    add(DE | SP, 6'd0, 16'd0, 1'b0, 3'd7, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0100);
    hold(1, 3'd0, 1'b0, 4'b0100);
    // Completion beats dma_error in the same cycle
    add(S, 6'd21, 16'd1, 1'b1, 3'd1, 1'b1, 6'd21, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    hold(1, 3'd2, 1'b1, 4'd0);
    add(CC, 6'd0, 16'd0, 1'b0, 3'd3, 1'b0, 6'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    hold(1, 3'd4, 1'b1, 4'd0);
    add(DT, 6'd0, 16'd0, 1'b0, 3'd4, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    add(DM | DE, 6'd0, 16'd0, 1'b0, 3'd7, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    hold(1, 3'd0, 1'b0, 4'd0);
    // Walk into WAIT_DATA before the asynchronous reset
    add(S, 6'd33, 16'd5, 1'b1, 3'd1, 1'b1, 6'd33, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
    hold(1, 3'd2, 1'b1, 4'd0);
    add(CC, 6'd0, 16'd0, 1'b0, 3'd3, 1'b0, 6'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    hold(1, 3'd4, 1'b1, 4'd0);
    split = tbl.size();
    // Fresh no-data command after reset release
    add(S, 6'd8, 16'd0, 1'b0, 3'd1, 1'b1, 6'd8, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    hold(1, 3'd2, 1'b0, 4'd0);
    add(CC, 6'd0, 16'd0, 1'b0, 3'd7, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    hold(1, 3'd0, 1'b0, 4'd0);

    repeat (2) @(posedge CLK);
    #1;
    chk("reset_state", dut_out(), 19'd0);
    @(negedge CLK);
    RESET = 1'b0;

    run_rows(0, split);

    #2;
    RESET = 1'b1;
    #1;
    chk("async_reset_immediate", dut_out(), 19'd0);
    @(posedge CLK);
    #1;
    chk("reset_held", dut_out(), 19'd0);
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    chk("post_release_quiet", dut_out(), 19'd0);

    run_rows(split, tbl.size());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
